// File: rtl/rv_pkg.sv
// rv_pkg: opcodes, imm/select codes, FSM encoding and instruction classes for mc_ctrl
package rv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] EXTOP_I = 3'b000;
  localparam logic [2:0] EXTOP_U = 3'b001;
  localparam logic [2:0] EXTOP_S = 3'b010;
  localparam logic [2:0] EXTOP_B = 3'b011;
  localparam logic [2:0] EXTOP_J = 3'b100;
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;
  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_FENCE, C_SYSTEM, C_ILLEGAL
  } iclass_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode to instruction class, imm_gen select, ALU operand selects and ALU control
module mc_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output iclass_t    cls,
  output logic [2:0] extop,
  output logic [3:0] alu_ctrl,
  output logic       a_sel,
  output logic       b_sel,
  output logic       legal
);
  always_comb begin
    cls = opcode == OPC_OP     ? C_OP     :
          opcode == OPC_OPIMM  ? C_OPIMM  :
          opcode == OPC_LUI    ? C_LUI    :
          opcode == OPC_AUIPC  ? C_AUIPC  :
          opcode == OPC_JAL    ? C_JAL    :
          opcode == OPC_JALR   ? C_JALR   :
          opcode == OPC_BRANCH ? C_BRANCH :
          opcode == OPC_LOAD   ? C_LOAD   :
          opcode == OPC_STORE  ? C_STORE  :
          opcode == OPC_FENCE  ? C_FENCE  :
          opcode == OPC_SYSTEM ? C_SYSTEM : C_ILLEGAL;
    extop = cls inside {C_LUI, C_AUIPC} ? EXTOP_U :
            cls == C_STORE              ? EXTOP_S :
            cls == C_BRANCH             ? EXTOP_B :
            cls == C_JAL                ? EXTOP_J : EXTOP_I;
    alu_ctrl = cls == C_OP     ? {f7b5, funct3} :
               cls == C_OPIMM  ? {f7b5 && funct3 == 3'b101, funct3} :
               cls == C_BRANCH ? {1'b0, funct3} : 4'b0000;
    a_sel = cls inside {C_LUI, C_AUIPC, C_JAL};
    b_sel = cls inside {C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_STORE};
    legal = cls != C_ILLEGAL;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control sequencer with retire counter and sticky halt/illegal flags
module mc_ctrl
  import rv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic [2:0]       extop,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [3:0]       alu_ctrl,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       dmem_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  logic [2:0] state, nxt;
  logic [2:0] dx;
  logic [3:0] dalu;
  logic       da, db, legal, act, ret;
  iclass_t    cls;
  logic       unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  mc_decode u_dec (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .f7b5     (instr[30]),
    .cls      (cls),
    .extop    (dx),
    .alu_ctrl (dalu),
    .a_sel    (da),
    .b_sel    (db),
    .legal    (legal)
  );
  always_comb begin
    act = state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
    nxt = state == ST_FETCH  ? (imem_ready ? ST_DECODE : ST_FETCH) :
          state == ST_DECODE ? (!legal || cls == C_SYSTEM ? ST_HALT :
                                cls == C_FENCE ? ST_FETCH : ST_EXEC) :
          state == ST_EXEC   ? (cls == C_BRANCH ? ST_FETCH :
                                cls inside {C_LOAD, C_STORE} ? ST_MEM : ST_WB) :
          state == ST_MEM    ? (!dmem_ready ? ST_MEM : cls == C_STORE ? ST_FETCH : ST_WB) :
          state == ST_WB     ? ST_FETCH : ST_HALT;
    ret = (state == ST_DECODE && cls == C_FENCE) ||
          (state == ST_EXEC && cls == C_BRANCH) ||
          (state == ST_MEM && dmem_ready && cls == C_STORE) ||
          state == ST_WB;
  end
  always_comb begin
    imem_req  = rst_n && state == ST_FETCH;
    ir_we     = imem_req && imem_ready;
    extop     = rst_n && act ? dx : EXTOP_I;
    alu_a_sel = rst_n && act && da;
    alu_b_sel = rst_n && act && db;
    alu_ctrl  = rst_n && act ? dalu : 4'b0000;
    dmem_req  = rst_n && state == ST_MEM;
    dmem_we   = dmem_req && cls == C_STORE;
    dmem_op   = dmem_req ? instr[14:12] : 3'b000;
    rf_we     = rst_n && state == ST_WB;
    wb_sel    = !rf_we ? WB_ALU : cls == C_LOAD ? WB_MEM :
                cls inside {C_JAL, C_JALR} ? WB_PC4 : WB_ALU;
    pc_we     = rst_n && ret;
    pc_sel    = !pc_we ? PC_PLUS4 :
                state == ST_EXEC ? (br_taken ? PC_REL : PC_PLUS4) :
                state == ST_WB && cls == C_JAL ? PC_REL :
                state == ST_WB && cls == C_JALR ? PC_JALR : PC_PLUS4;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      halted  <= 1'b0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= nxt;
      if (state == ST_DECODE && !legal) illegal <= 1'b1;
      if (state == ST_DECODE && cls == C_SYSTEM) halted <= 1'b1;
      if (ret) instret <= instret + CNT_W'(1);
    end
  end
endmodule
